alu6: RTL and testbench

- 6-bit registered ALU with eight operations selected by a 3-bit control field {f,x,n}.
- Produces a 6-bit result, which is either an arithmetic/logic value or a signed less-than flag, plus carry, overflow and zero status.
- Sits as a leaf datapath block; one clock domain, no handshake, one result per cycle.

---
 rtl/alu6.sv | 102 ++++++++++
 tb/tb_alu6.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu6.sv
// alu6: registered WIDTH-bit ALU. The opcode {f,x,n} selects one of eight operations.
// The result, carry, overflow and zero flags are all computed combinationally.
// They are captured together in a single register stage on the rising clock edge.
module alu6 #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             f,
    input  logic             x,
    input  logic             n,
    output logic [WIDTH-1:0] num_or_less_than,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    // The shift amount field is the low log2(WIDTH) bits of operand B.
    localparam int unsigned ShW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpAnd = 3'b010,
        OpOr  = 3'b011,
        OpXor = 3'b100,
        OpNot = 3'b101,
        OpShl = 3'b110,
        OpSlt = 3'b111
    } op_e;

    op_e              op;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             a_lt_b;

    logic [WIDTH-1:0] result_d, result_q;
    logic             carry_d, carry_q;
    logic             ovf_d, ovf_q;
    logic             zero_d, zero_q;

    assign op = op_e'({f, x, n});

    // Shared arithmetic terms. The extra MSB of each holds the carry or borrow out.
    always_comb begin
        sum_ext  = {1'b0, input1} + {1'b0, input2};
        diff_ext = {1'b0, input1} - {1'b0, input2};
        a_lt_b   = $signed(input1) < $signed(input2);
    end

    // Next-state selection. Carry and overflow are meaningful only for ADD and SUB.
    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        unique case (op)
            OpAdd: begin
                result_d = sum_ext[WIDTH-1:0];
                carry_d  = sum_ext[WIDTH];
                ovf_d    = (input1[WIDTH-1] == input2[WIDTH-1]) &&
                           (sum_ext[WIDTH-1] != input1[WIDTH-1]);
            end
            OpSub: begin
                result_d = diff_ext[WIDTH-1:0];
                carry_d  = diff_ext[WIDTH];   // borrow: A < B unsigned
                ovf_d    = (input1[WIDTH-1] != input2[WIDTH-1]) &&
                           (diff_ext[WIDTH-1] != input1[WIDTH-1]);
            end
            OpAnd: result_d = input1 & input2;
            OpOr:  result_d = input1 | input2;
            OpXor: result_d = input1 ^ input2;
            OpNot: result_d = ~input1;
            // Amounts at or beyond WIDTH shift every bit out, giving 0.
            OpShl: result_d = input1 << input2[ShW-1:0];
            OpSlt: result_d = {{(WIDTH-1){1'b0}}, a_lt_b};
        endcase
        zero_d = (result_d == '0);
    end

    // Output register stage. Reset clears every flag, and zero clears as well.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign num_or_less_than = result_q;
    assign carry_out        = carry_q;
    assign overflow         = ovf_q;
    assign zero             = zero_q;

endmodule

// File: tb/tb_alu6.sv
// Scoreboard bench for alu6.
// The driver pushes the expected response for each vector captured at the next edge.
// The monitor pops that entry and compares it one time unit after the edge.
module tb_alu6;

    localparam int unsigned W = 6;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] OR  = 3'b011;
    localparam logic [2:0] XOR = 3'b100;
    localparam logic [2:0] NOT = 3'b101;
    localparam logic [2:0] SHL = 3'b110;
    localparam logic [2:0] SLT = 3'b111;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] input1, input2;
    logic         f, x, n;
    logic [W-1:0] num_or_less_than;
    logic         carry_out, overflow, zero;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
        string        name;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    alu6 #(.WIDTH(W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .input1           (input1),
        .input2           (input2),
        .f                (f),
        .x                (x),
        .n                (n),
        .num_or_less_than (num_or_less_than),
        .carry_out        (carry_out),
        .overflow         (overflow),
        .zero             (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one vector at the falling edge and queue the response expected after the next rise.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                         input logic [W-1:0] res, input logic c, input logic v, input logic z,
                         input string name);
        exp_t e;
        @(negedge clk);
        input1 = a;
        input2 = b;
        {f, x, n} = op;
        e.res = res; e.c = c; e.v = v; e.z = z; e.name = name;
        sb_q.push_back(e);
    endtask

    // Check the outputs directly, without the scoreboard (used for the reset checks).
    task automatic check_now(input logic [W-1:0] res, input logic c, input logic v,
                             input logic z, input string name);
        checks++;
        if (num_or_less_than !== res || carry_out !== c || overflow !== v || zero !== z) begin
            failures++;
            $display("FAIL %s: got res=%b c=%b v=%b z=%b, expected res=%b c=%b v=%b z=%b",
                     name, num_or_less_than, carry_out, overflow, zero, res, c, v, z);
        end
    endtask

    // Monitor: one registered result per edge, compared against the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (rst_n && sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (num_or_less_than !== e.res || carry_out !== e.c || overflow !== e.v ||
                zero !== e.z) begin
                failures++;
                $display("FAIL %s: got res=%b c=%b v=%b z=%b, expected res=%b c=%b v=%b z=%b",
                         e.name, num_or_less_than, carry_out, overflow, zero,
                         e.res, e.c, e.v, e.z);
            end
        end
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic         lt;
        int           waited;

        input1 = '0; input2 = '0; {f, x, n} = ADD;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_now('0, 1'b0, 1'b0, 1'b0, "reset_state");
        repeat (2) @(posedge clk);
        #2 check_now('0, 1'b0, 1'b0, 1'b0, "reset_hold_initial");
        @(negedge clk);
        rst_n = 1'b1;

        // SLT
        issue(6'b111101, 6'd5, SLT, 6'b000001, 0, 0, 0, "slt_neg3_lt_5");
        issue(6'd5, 6'b111101, SLT, 6'b000000, 0, 0, 1, "slt_5_lt_neg3");
        issue(6'd9, 6'd9, SLT, 6'b000000, 0, 0, 1, "slt_equal");
        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom_range(0, 63));
            rb = W'($urandom_range(0, 63));
            lt = $signed(ra) < $signed(rb);
            issue(ra, rb, SLT, {5'b0, lt}, 0, 0, !lt, $sformatf("slt_rand%0d", i));
            repeat (19) @(negedge clk);   // one vector per 200 ns
        end

        // ADD
        issue(6'd31, 6'd1, ADD, 6'd32, 0, 1, 0, "add_31_1");
        issue(6'd63, 6'd1, ADD, 6'd0, 1, 0, 1, "add_63_1");
        issue(6'd10, 6'd20, ADD, 6'd30, 0, 0, 0, "add_10_20");

        // SUB
        issue(6'd5, 6'd7, SUB, 6'd62, 1, 0, 0, "sub_5_7");
        issue(6'd32, 6'd1, SUB, 6'd31, 0, 1, 0, "sub_m32_1");
        issue(6'd7, 6'd7, SUB, 6'd0, 0, 0, 1, "sub_7_7");

        // Logic and shift
        issue(6'b101100, 6'b011010, AND, 6'b001000, 0, 0, 0, "and");
        issue(6'b101100, 6'b011010, OR,  6'b111110, 0, 0, 0, "or");
        issue(6'b101100, 6'b011010, XOR, 6'b110110, 0, 0, 0, "xor");
        issue(6'b101100, 6'b011010, NOT, 6'b010011, 0, 0, 0, "not");
        issue(6'b000011, 6'd2, SHL, 6'b001100, 0, 0, 0, "shl_by2");
        issue(6'b000011, 6'd7, SHL, 6'b000000, 0, 0, 1, "shl_by7");
        issue(6'b000011, 6'd6, SHL, 6'b000000, 0, 0, 1, "shl_by6");
        issue(6'b000011, 6'b111010, SHL, 6'b001100, 0, 0, 0, "shl_ignore_hi");

        // Back-to-back vectors, with the opcode changing every cycle
        issue(6'd1,  6'd2,  ADD, 6'd3,  0, 0, 0, "seq_add");
        issue(6'd9,  6'd3,  SUB, 6'd6,  0, 0, 0, "seq_sub");
        issue(6'd12, 6'd10, AND, 6'd8,  0, 0, 0, "seq_and");
        issue(6'd12, 6'd10, OR,  6'd14, 0, 0, 0, "seq_or");
        issue(6'd12, 6'd10, XOR, 6'd6,  0, 0, 0, "seq_xor");
        issue(6'd12, 6'd10, NOT, 6'd51, 0, 0, 0, "seq_not");
        issue(6'd1,  6'd5,  SHL, 6'd32, 0, 0, 0, "seq_shl");
        issue(6'd60, 6'd2,  SLT, 6'd1,  0, 0, 0, "seq_slt");
        issue(6'd0,  6'd0,  ADD, 6'd0,  0, 0, 1, "seq_add_zero");
        issue(6'd0,  6'd1,  SUB, 6'd63, 1, 0, 0, "seq_sub_borrow");

        // Mid-stream reset: bring the outputs to nonzero values first
        issue(6'd20, 6'd20, ADD, 6'd40, 0, 1, 0, "pre_reset_add");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_now('0, 1'b0, 1'b0, 1'b0, "async_reset_clear");
        input1 = 6'd10; input2 = 6'd20; {f, x, n} = ADD;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2 check_now('0, 1'b0, 1'b0, 1'b0, $sformatf("reset_hold%0d", i));
        end
        @(negedge clk);
        rst_n = 1'b1;
        begin
            exp_t e;
            e.res = 6'd30; e.c = 0; e.v = 0; e.z = 0; e.name = "first_after_release";
            sb_q.push_back(e);
        end

        // Drain the scoreboard, with a bound on the wait
        waited = 0;
        while (sb_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
